// File: rtl/filter_bank_controller_if.sv
// filter_bank_controller_if: handshake bundle between the control unit, the DMA/conv engine and the filter bank controller
// master: drives start/depth/numFilters/dmaFinish/oneConvFinish, observes controller status
// slave : the controller itself
// FC_ABORT_EN adds abort (master -> slave) and aborted (slave -> master)
interface filter_bank_controller_if #(
  parameter int DEPTH_W  = 3,
  parameter int FILTER_W = 4
);
  logic                start;
  logic [DEPTH_W-1:0]  depth;
  logic [FILTER_W-1:0] numFilters;
  logic                dmaFinish;
  logic                oneConvFinish;
  logic                loadConfig;
  logic                startOneConv;
  logic                filterLastLayer;
  logic [DEPTH_W-1:0]  layerIdx;
  logic [FILTER_W-1:0] filterIdx;
  logic                busy;
  logic                finish;
`ifdef FC_ABORT_EN
  logic                abort;
  logic                aborted;
  modport master (
    output start, depth, numFilters, dmaFinish, oneConvFinish, abort,
    input  loadConfig, startOneConv, filterLastLayer, layerIdx, filterIdx, busy, finish, aborted
  );
  modport slave (
    input  start, depth, numFilters, dmaFinish, oneConvFinish, abort,
    output loadConfig, startOneConv, filterLastLayer, layerIdx, filterIdx, busy, finish, aborted
  );
`else
  modport master (
    output start, depth, numFilters, dmaFinish, oneConvFinish,
    input  loadConfig, startOneConv, filterLastLayer, layerIdx, filterIdx, busy, finish
  );
  modport slave (
    input  start, depth, numFilters, dmaFinish, oneConvFinish,
    output loadConfig, startOneConv, filterLastLayer, layerIdx, filterIdx, busy, finish
  );
`endif
endinterface

// File: rtl/filter_bank_controller.sv
// filter_bank_controller: sequences a multi-layer filter pass (per layer: config load, then one conv per filter)
// clk        : rising-edge clock
// resetState : asynchronous reset, active low
// bus        : filter_bank_controller_if.slave (start/depth/numFilters/dmaFinish/oneConvFinish in,
//              loadConfig/startOneConv/filterLastLayer/layerIdx/filterIdx/busy/finish out)
// FC_ABORT_EN: when defined, adds bus.abort / bus.aborted for cancelling a pass
module filter_bank_controller #(
  parameter int DEPTH_W  = 3,
  parameter int FILTER_W = 4
) (
  input logic                    clk,
  input logic                    resetState,
  filter_bank_controller_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD_CFG, ISSUE, WAIT_CONV, DONE} state_t;
  state_t              state_q, state_d;
  logic [DEPTH_W-1:0]  layer_q, layer_d, depth_q, depth_d;
  logic [FILTER_W-1:0] filter_q, filter_d, numf_q, numf_d;
`ifdef FC_ABORT_EN
  logic                aborted_q, aborted_d;
`endif
  always_ff @(posedge clk or negedge resetState) begin
    if (!resetState) begin
      state_q  <= IDLE;
      layer_q  <= '0;
      filter_q <= '0;
      depth_q  <= '0;
      numf_q   <= '0;
`ifdef FC_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      layer_q  <= layer_d;
      filter_q <= filter_d;
      depth_q  <= depth_d;
      numf_q   <= numf_d;
`ifdef FC_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end
  // Limits are compared against the values latched at start, so input changes mid-pass have no effect.
  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    filter_d = filter_q;
    depth_d  = depth_q;
    numf_d   = numf_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d  = LOAD_CFG;
        depth_d  = bus.depth;
        numf_d   = bus.numFilters;
        layer_d  = '0;
        filter_d = '0;
      end
      LOAD_CFG: state_d = bus.dmaFinish ? ISSUE : LOAD_CFG;
      ISSUE: state_d = WAIT_CONV;
      WAIT_CONV: if (bus.oneConvFinish) begin
        if (filter_q != numf_q) begin
          filter_d = filter_q + 1'b1;
          state_d  = ISSUE;
        end else if (layer_q != depth_q) begin
          filter_d = '0;
          layer_d  = layer_q + 1'b1;
          state_d  = LOAD_CFG;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d  = IDLE;
        layer_d  = '0;
        filter_d = '0;
      end
      default: state_d = IDLE;
    endcase
`ifdef FC_ABORT_EN
    // Abort overrides whatever the handshakes decided this cycle.
    aborted_d = 1'b0;
    if (bus.abort && state_q != IDLE) begin
      state_d   = IDLE;
      layer_d   = '0;
      filter_d  = '0;
      aborted_d = 1'b1;
    end
`endif
  end
  assign bus.loadConfig      = state_q == LOAD_CFG;
  assign bus.startOneConv    = state_q == ISSUE;
  assign bus.finish          = state_q == DONE;
  assign bus.busy            = state_q != IDLE;
  assign bus.filterLastLayer = state_q != IDLE && layer_q == depth_q;
  assign bus.layerIdx        = layer_q;
  assign bus.filterIdx       = filter_q;
`ifdef FC_ABORT_EN
  assign bus.aborted         = aborted_q;
`endif
endmodule
